// File: rtl/fetch_stage_unit_if.sv
// rtl/fetch_stage_unit_if.sv - fetch stage control, instruction memory and IF/ID bundle
interface fetch_stage_unit_if #(
   parameter int CNT_W = 16
);
   logic              PCWrite;
   logic              IF_ID_Write;
   logic              Redirect;
   logic [31:0]       RedirectTarget;
   logic [31:0]       IMemAddr;
   logic [31:0]       IMemData;
   logic [31:0]       PC;
   logic [31:0]       IF_ID_Instruction;
   logic [31:0]       IF_ID_PCPlus4;
   logic              IF_ID_Valid;
   logic [CNT_W-1:0]  StallCount;
   logic [CNT_W-1:0]  FlushCount;

   // master: hazard unit, redirect source and instruction memory
   modport master (
      output PCWrite, IF_ID_Write, Redirect, RedirectTarget, IMemData,
      input  IMemAddr, PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
             StallCount, FlushCount
   );

   modport slave (
      input  PCWrite, IF_ID_Write, Redirect, RedirectTarget, IMemData,
      output IMemAddr, PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
             StallCount, FlushCount
   );
endinterface

// File: rtl/fetch_stage_unit.sv
// rtl/fetch_stage_unit.sv - MIPS IF stage with PC, IF/ID register and stall/flush counters
// Optional branch delay slot behaviour on redirect: define FETCH_DELAY_SLOT_EN.
module fetch_stage_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_INC   = 4,
   parameter int          CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   fetch_stage_unit_if.slave bus
);
   logic [31:0]      pc;
   logic [31:0]      pc_next_seq;
   logic [31:0]      if_id_instr;
   logic [31:0]      if_id_pcp4;
   logic             if_id_valid;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   assign pc_next_seq = pc + 32'(PC_INC);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pc          <= RESET_PC;
         if_id_instr <= 32'h0;
         if_id_pcp4  <= 32'h0;
         if_id_valid <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else if (bus.Redirect) begin
         // redirect wins over any stall request in the same cycle
         pc <= bus.RedirectTarget & ~32'h3;
`ifdef FETCH_DELAY_SLOT_EN
         if_id_instr <= bus.IMemData;
         if_id_pcp4  <= pc_next_seq;
         if_id_valid <= 1'b1;
`else
         if_id_instr <= 32'h0;
         if_id_pcp4  <= 32'h0;
         if_id_valid <= 1'b0;
`endif
         if (flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
         if (bus.PCWrite)
            pc <= pc_next_seq;
         if (bus.IF_ID_Write) begin
            if_id_instr <= bus.IMemData;
            if_id_pcp4  <= pc_next_seq;
            if_id_valid <= 1'b1;
         end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.IMemAddr          = pc;
   assign bus.PC                = pc;
   assign bus.IF_ID_Instruction = if_id_instr;
   assign bus.IF_ID_PCPlus4     = if_id_pcp4;
   assign bus.IF_ID_Valid       = if_id_valid;
   assign bus.StallCount        = stall_cnt;
   assign bus.FlushCount        = flush_cnt;
endmodule

// File: tb/tb_fetch_stage_unit.sv
// tb/tb_fetch_stage_unit.sv - directed vector bench for fetch_stage_unit
module tb_fetch_stage_unit;
   logic clk;
   logic rst_n;

   fetch_stage_unit_if #(.CNT_W(16)) mif ();
   fetch_stage_unit_if #(.CNT_W(2))  sif ();

   fetch_stage_unit #(.RESET_PC(32'h0), .PC_INC(4), .CNT_W(16)) dut (
      .Clk(clk), .Reset_n(rst_n), .bus(mif)
   );
   fetch_stage_unit #(.RESET_PC(32'h0), .PC_INC(4), .CNT_W(2)) dut_sat (
      .Clk(clk), .Reset_n(rst_n), .bus(sif)
   );

   // instruction memory: word at address A is 0x1000_0000 + A
   assign mif.IMemData = 32'h1000_0000 + mif.IMemAddr;
   assign sif.IMemData = 32'h1000_0000 + sif.IMemAddr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        redir;
      logic        pw;
      logic        iw;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pcp4;
      logic        valid;
      logic [15:0] stall;
      logic [15:0] flush;
   } vec_t;

   vec_t vecs [14];
   int   n_checks;
   int   n_fails;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_main(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] pcp4, input logic valid,
                           input logic [15:0] stall, input logic [15:0] flush);
      chk({tag, " PC"},       mif.PC, pc);
      chk({tag, " IMemAddr"}, mif.IMemAddr, pc);
      chk({tag, " Instr"},    mif.IF_ID_Instruction, instr);
      chk({tag, " PCPlus4"},  mif.IF_ID_PCPlus4, pcp4);
      chk({tag, " Valid"},    32'(mif.IF_ID_Valid), 32'(valid));
      chk({tag, " Stall"},    32'(mif.StallCount), 32'(stall));
      chk({tag, " Flush"},    32'(mif.FlushCount), 32'(flush));
   endtask

   task automatic drive(input logic redir, input logic pw, input logic iw, input logic [31:0] tgt);
      mif.Redirect       = redir;
      mif.PCWrite        = pw;
      mif.IF_ID_Write    = iw;
      mif.RedirectTarget = tgt;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;

      //          redir pw   iw   target        pc            instr         pcp4          v     stall flush
      vecs[0]  = '{1'b0,1'b1,1'b1,32'h0,        32'h4,        32'h1000_0000,32'h4,        1'b1, 16'd0,16'd0};
      vecs[1]  = '{1'b0,1'b1,1'b1,32'h0,        32'h8,        32'h1000_0004,32'h8,        1'b1, 16'd0,16'd0};
      vecs[2]  = '{1'b0,1'b1,1'b1,32'h0,        32'hC,        32'h1000_0008,32'hC,        1'b1, 16'd0,16'd0};
      vecs[3]  = '{1'b0,1'b1,1'b1,32'h0,        32'h10,       32'h1000_000C,32'h10,       1'b1, 16'd0,16'd0};
      vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,        32'h10,       32'h1000_000C,32'h10,       1'b1, 16'd1,16'd0};
      vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,        32'h10,       32'h1000_000C,32'h10,       1'b1, 16'd2,16'd0};
      vecs[6]  = '{1'b0,1'b1,1'b1,32'h0,        32'h14,       32'h1000_0010,32'h14,       1'b1, 16'd2,16'd0};
`ifdef FETCH_DELAY_SLOT_EN
      vecs[7]  = '{1'b1,1'b0,1'b0,32'h103,      32'h100,      32'h1000_0014,32'h18,       1'b1, 16'd2,16'd1};
`else
      vecs[7]  = '{1'b1,1'b0,1'b0,32'h103,      32'h100,      32'h0,        32'h0,        1'b0, 16'd2,16'd1};
`endif
      vecs[8]  = '{1'b0,1'b1,1'b1,32'h0,        32'h104,      32'h1000_0100,32'h104,      1'b1, 16'd2,16'd1};
      vecs[9]  = '{1'b0,1'b1,1'b0,32'h0,        32'h108,      32'h1000_0100,32'h104,      1'b1, 16'd3,16'd1};
      vecs[10] = '{1'b0,1'b0,1'b1,32'h0,        32'h108,      32'h1000_0108,32'h10C,      1'b1, 16'd3,16'd1};
`ifdef FETCH_DELAY_SLOT_EN
      vecs[11] = '{1'b1,1'b1,1'b1,32'hFFFF_FFFE,32'hFFFF_FFFC,32'h1000_0108,32'h10C,      1'b1, 16'd3,16'd2};
`else
      vecs[11] = '{1'b1,1'b1,1'b1,32'hFFFF_FFFE,32'hFFFF_FFFC,32'h0,        32'h0,        1'b0, 16'd3,16'd2};
`endif
      vecs[12] = '{1'b0,1'b1,1'b1,32'h0,        32'h0,        32'h0FFF_FFFC,32'h0,        1'b1, 16'd3,16'd2};
      vecs[13] = '{1'b0,1'b1,1'b1,32'h0,        32'h4,        32'h1000_0000,32'h4,        1'b1, 16'd3,16'd2};

      rst_n = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 32'h0);
      sif.Redirect       = 1'b0;
      sif.PCWrite        = 1'b0;
      sif.IF_ID_Write    = 1'b0;
      sif.RedirectTarget = 32'h0;
      @(posedge clk);
      @(negedge clk);
      chk_main("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].redir, vecs[i].pw, vecs[i].iw, vecs[i].tgt);
         @(posedge clk);
         @(negedge clk);
         chk_main($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pcp4,
                  vecs[i].valid, vecs[i].stall, vecs[i].flush);
      end

      // free run up to PC=0x40, then pulse reset between edges
      drive(1'b0, 1'b1, 1'b1, 32'h0);
      for (int k = 0; k < 32 && mif.PC != 32'h40; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("reach_pc_40", mif.PC, 32'h40);
      #2;
      rst_n = 1'b0;
      #1;
      chk_main("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
      chk("sat_reset_stall", 32'(sif.StallCount), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // first fetch after release is at 0; CNT_W=2 instance saturates at 3
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 0)
            chk_main("post_reset", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 16'd0, 16'd0);
         chk($sformatf("sat_stall%0d", c), 32'(sif.StallCount), (c < 3) ? c + 1 : 3);
         chk($sformatf("sat_pc%0d", c), sif.PC, 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
